uart_rx: RTL and testbench
==========================

// Module: uart_rx
//
// PURPOSE
// Serial receiver closing the loop on the UART_TX transmitter: recovers frames of
// start(0) + data_width bits (LSB first) + optional parity + stop(1) from RX_IN.
// CLK runs at OVERSAMPLE x bit rate; each bit is majority-voted at mid-bit.
// Delivers parallel word with a 1-cycle valid strobe and per-frame error flags.
//
// PARAMETERS
// data_width  8  data bits per frame (same meaning as the transmitter)
// OVERSAMPLE  8  CLK cycles per bit; power of two, >= 8
//
// PORTS
// CLK         in   1           oversampling clock
// RST         in   1           asynchronous reset, active-low
// RX_IN       in   1           serial line, idle high
// PAR_EN      in   1           1 = frame carries parity bit
// PAR_Type    in   1           0 = even, 1 = odd (matches transmitter)
// P_Data      out  data_width  last good received word
// Data_Valid  out  1           1-cycle pulse: P_Data updated, frame clean
// PAR_Err     out  1           1-cycle pulse: parity mismatch
// STP_Err     out  1           1-cycle pulse: stop bit sampled 0
// BUSY        out  1           high while not in IDLE
//
// BEHAVIOUR
// - Reset (RST=0, async): state IDLE, counters 0, P_Data=0, all pulses 0, BUSY=0.
// - edge_cnt counts 0..OVERSAMPLE-1 within a bit; bit_cnt counts data bits.
// - Samples at edge_cnt = OS/2-1, OS/2, OS/2+1; bit value = majority of 3.
// - FSM: IDLE, START, DATA, PARITY, STOP.
//   IDLE:   RX_IN==0 -> START, edge_cnt=0; latch PAR_EN/PAR_Type for whole frame.
//   START:  at edge_cnt==OS/2+2: voted 1 -> IDLE (glitch, no outputs); else
//           continue to end of bit -> DATA.
//   DATA:   shift voted bit into MSB of shift reg (LSB-first line order);
//           after data_width bits -> PARITY if latched PAR_EN, else STOP.
//   PARITY: compare voted bit with XOR(data) ^ PAR_Type.
//   STOP:   at edge_cnt==OS/2+2 evaluate frame, return to IDLE (half bit early
//           so a back-to-back start edge is caught with no gap).
// - Frame end (single cycle): clean -> P_Data<=shift reg, Data_Valid=1;
//   parity bad -> PAR_Err=1; stop bad -> STP_Err=1; both may pulse together.
//   Any error: Data_Valid stays 0, P_Data holds previous word.
// - Latency: Data_Valid rises OS/2+3 CLK after the stop bit's first cycle on RX_IN
//   (+2 with sync stage).
// - PAR_EN/PAR_Type changes mid-frame are ignored until next IDLE->START.
// - RX_IN low in IDLE for the cycle after frame end starts a new frame.
// - Line stuck low: each frame yields STP_Err; FSM re-arms from IDLE, no lockup.
// - Reset mid-frame: immediate abort, no pulses, next frame received normally.
//
// CONFIGURATION
// UART_RX_SYNC_EN defined: RX_IN passes a 2-flop synchronizer (reset to 1) before
//   edge detect/voting; all RX timing shifts by +2 CLK.
// Not defined: RX_IN used directly (caller guarantees it is synchronous to CLK).
//
// TESTING (OVERSAMPLE=8, data_width=8, bits driven 8 CLK each)
// 1. PAR_EN=1,PAR_Type=0, send 0xA5 parity 0 -> P_Data=0xA5, Data_Valid 1 cycle,
//    PAR_Err=STP_Err=0.
// 2. After 1, send 0x3C with parity bit 1 (even) -> PAR_Err pulse, Data_Valid=0,
//    P_Data stays 0xA5.
// 3. PAR_EN=0, send 0x81 with stop=0 -> STP_Err pulse, no Data_Valid; next
//    clean 0x42 -> P_Data=0x42.
// 4. RX_IN low for 2 CLK in IDLE -> back to IDLE at start mid-bit, no pulses,
//    BUSY high only that bit.
// 5. Three back-to-back frames 0x00,0xFF,0x55, no idle gap -> three Data_Valid
//    pulses with correct data.
// 6. Assert RST during DATA bit 4 -> outputs reset values; next 0x99 received
//    correctly. Repeat 1 and 5 with UART_RX_SYNC_EN defined.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Oversampling UART receiver. Recovers frames of
//   start(0) + data_width data bits (LSB first) + optional parity + stop(1)
//   from RX_IN. CLK runs at OVERSAMPLE x the bit rate. Each bit is taken as
//   the majority of three samples around mid-bit.
//
//   Optional build macro:
//     UART_RX_SYNC_EN  RX_IN passes a 2-flop synchronizer (reset to 1) before
//                      edge detection and voting. All RX timing shifts by +2 CLK.
//                      When undefined, RX_IN must already be synchronous to CLK.
//
// Parameters
//   data_width  data bits per frame
//   OVERSAMPLE  CLK cycles per bit (power of two, >= 8)
//
// Ports
//   CLK         oversampling clock
//   RST         asynchronous reset, active-low
//   RX_IN       serial line, idle high
//   PAR_EN      1 = frame carries a parity bit (latched at frame start)
//   PAR_Type    0 = even, 1 = odd (latched at frame start)
//   P_Data      last cleanly received word
//   Data_Valid  1-cycle pulse: P_Data updated, frame clean
//   PAR_Err     1-cycle pulse: parity mismatch
//   STP_Err     1-cycle pulse: stop bit sampled 0
//   BUSY        high while the FSM is not idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
  parameter int data_width = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_Type,
  output logic [data_width-1:0] P_Data,
  output logic                  Data_Valid,
  output logic                  PAR_Err,
  output logic                  STP_Err,
  output logic                  BUSY
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(data_width + 1);

  // Sample points straddle mid-bit; the vote is consumed one cycle after the
  // last sample, once all three samples are registered.
  localparam logic [EW-1:0] C_SAMP0   = EW'(OVERSAMPLE / 2 - 1);
  localparam logic [EW-1:0] C_SAMP1   = EW'(OVERSAMPLE / 2);
  localparam logic [EW-1:0] C_SAMP2   = EW'(OVERSAMPLE / 2 + 1);
  localparam logic [EW-1:0] C_EVAL    = EW'(OVERSAMPLE / 2 + 2);
  localparam logic [EW-1:0] C_LAST    = EW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_LASTBIT = BW'(data_width - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [EW-1:0]         r_edge;
  logic [BW-1:0]         r_bit;
  logic [2:0]            r_samp;
  logic [data_width-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_type;
  logic                  r_par_bad;
  logic                  w_rx;
  logic                  w_vote;

  function automatic logic f_vote(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

`ifdef UART_RX_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Reset to the idle level so a reset never looks like a start edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;
`else
  assign w_rx = RX_IN;
`endif

  assign w_vote = f_vote(r_samp);

  // Mid-bit samples; values captured while idle are overwritten before use.
  always_ff @(posedge CLK) begin
    if (r_edge == C_SAMP0) r_samp[0] <= w_rx;
    if (r_edge == C_SAMP1) r_samp[1] <= w_rx;
    if (r_edge == C_SAMP2) r_samp[2] <= w_rx;
  end

  // Line order is LSB first, so shifting in at the MSB leaves bit 0 at the
  // bottom after the last data bit.
  always_ff @(posedge CLK) begin
    if (r_state == S_DATA && r_edge == C_LAST)
      r_shift <= {w_vote, r_shift[data_width-1:1]};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_edge     <= '0;
      r_bit      <= '0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_par_bad  <= 1'b0;
      P_Data     <= '0;
      Data_Valid <= 1'b0;
      PAR_Err    <= 1'b0;
      STP_Err    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      PAR_Err    <= 1'b0;
      STP_Err    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state    <= S_START;
            r_edge     <= '0;
            r_bit      <= '0;
            r_par_en   <= PAR_EN;
            r_par_type <= PAR_Type;
            r_par_bad  <= 1'b0;
            BUSY       <= 1'b1;
          end
        end

        S_START: begin
          // A start bit that votes high at mid-bit was only a glitch.
          if (r_edge == C_EVAL && w_vote) begin
            r_state <= S_IDLE;
            BUSY    <= 1'b0;
          end else if (r_edge == C_LAST) begin
            r_edge  <= '0;
            r_state <= S_DATA;
          end else begin
            r_edge <= r_edge + 1'b1;
          end
        end

        S_DATA: begin
          if (r_edge == C_LAST) begin
            r_edge <= '0;
            if (r_bit == C_LASTBIT) begin
              r_bit   <= '0;
              r_state <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_edge <= r_edge + 1'b1;
          end
        end

        S_PARITY: begin
          if (r_edge == C_LAST) begin
            r_edge    <= '0;
            r_state   <= S_STOP;
            r_par_bad <= (w_vote != ((^r_shift) ^ r_par_type));
          end else begin
            r_edge <= r_edge + 1'b1;
          end
        end

        S_STOP: begin
          // Finish half a bit early so a back-to-back start edge at the end
          // of the stop bit is seen from IDLE with no gap.
          if (r_edge == C_EVAL) begin
            r_state <= S_IDLE;
            r_edge  <= '0;
            BUSY    <= 1'b0;
            if (!w_vote)  STP_Err <= 1'b1;
            if (r_par_bad) PAR_Err <= 1'b1;
            if (w_vote && !r_par_bad) begin
              Data_Valid <= 1'b1;
              P_Data     <= r_shift;
            end
          end else begin
            r_edge <= r_edge + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_edge  <= '0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int OS = 8;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 9;   // 7 edges after the stop bit is first sampled, +2 sync
`else
  localparam int LAT = 7;
`endif

  logic       CLK      = 1'b0;
  logic       RST      = 1'b1;
  logic       RX_IN    = 1'b1;
  logic       PAR_EN   = 1'b0;
  logic       PAR_Type = 1'b0;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       PAR_Err;
  logic       STP_Err;
  logic       BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc      = 0;
  int dv_cnt   = 0;
  int pe_cnt   = 0;
  int se_cnt   = 0;
  int dv_cyc   = 0;
  int stop_cyc = 0;
  logic [7:0] rx_q[$];

  uart_rx #(.data_width(8), .OVERSAMPLE(OS)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_Type  (PAR_Type),
    .P_Data    (P_Data),
    .Data_Valid(Data_Valid),
    .PAR_Err   (PAR_Err),
    .STP_Err   (STP_Err),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (Data_Valid) begin
      dv_cnt = dv_cnt + 1;
      dv_cyc = cyc;
      rx_q.push_back(P_Data);
    end
    if (PAR_Err) pe_cnt = pe_cnt + 1;
    if (STP_Err) se_cnt = se_cnt + 1;
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    RX_IN = b;
    repeat (OS) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen,
                            input logic pbit, input logic stopb);
    PAR_EN = pen;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    stop_cyc = cyc + 1;   // cycle number of the first edge sampling the stop bit
    send_bit(stopb);
  endtask

  task automatic test_reset;
    #2 RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_checks++; if (P_Data !== 8'h00) begin n_fail++; $display("FAIL reset_pdata: got %h want 00", P_Data); end
    n_checks++; if (Data_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b want 0", Data_Valid); end
    n_checks++; if (PAR_Err !== 1'b0) begin n_fail++; $display("FAIL reset_pe: got %b want 0", PAR_Err); end
    n_checks++; if (STP_Err !== 1'b0) begin n_fail++; $display("FAIL reset_se: got %b want 0", STP_Err); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    @(posedge CLK); #1;
    RST = 1'b1;
    idle(4);
  endtask

  // 0xA5 has four ones: even parity bit is 0.
  task automatic test_good_parity;
    int dv0, pe0, se0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    PAR_Type = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    idle(12);
    n_checks++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("FAIL t1_dv_count: got %0d want 1", dv_cnt - dv0); end
    n_checks++; if (P_Data !== 8'hA5) begin n_fail++; $display("FAIL t1_pdata: got %h want a5", P_Data); end
    n_checks++; if (pe_cnt - pe0 !== 0) begin n_fail++; $display("FAIL t1_pe: got %0d want 0", pe_cnt - pe0); end
    n_checks++; if (se_cnt - se0 !== 0) begin n_fail++; $display("FAIL t1_se: got %0d want 0", se_cnt - se0); end
    n_checks++; if (dv_cyc - stop_cyc !== LAT) begin n_fail++; $display("FAIL t1_latency: got %0d want %0d", dv_cyc - stop_cyc, LAT); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL t1_busy_after: got %b want 0", BUSY); end
  endtask

  // 0x3C has four ones: even parity should be 0, send 1.
  task automatic test_bad_parity;
    int dv0, pe0, se0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    PAR_Type = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle(12);
    n_checks++; if (pe_cnt - pe0 !== 1) begin n_fail++; $display("FAIL t2_pe_count: got %0d want 1", pe_cnt - pe0); end
    n_checks++; if (dv_cnt - dv0 !== 0) begin n_fail++; $display("FAIL t2_dv_count: got %0d want 0", dv_cnt - dv0); end
    n_checks++; if (se_cnt - se0 !== 0) begin n_fail++; $display("FAIL t2_se: got %0d want 0", se_cnt - se0); end
    n_checks++; if (P_Data !== 8'hA5) begin n_fail++; $display("FAIL t2_pdata_hold: got %h want a5", P_Data); end
  endtask

  task automatic test_stop_error;
    int dv0, pe0, se0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    idle(12);
    n_checks++; if (se_cnt - se0 !== 1) begin n_fail++; $display("FAIL t3_se_count: got %0d want 1", se_cnt - se0); end
    n_checks++; if (dv_cnt - dv0 !== 0) begin n_fail++; $display("FAIL t3_dv_count: got %0d want 0", dv_cnt - dv0); end
    n_checks++; if (pe_cnt - pe0 !== 0) begin n_fail++; $display("FAIL t3_pe: got %0d want 0", pe_cnt - pe0); end
    n_checks++; if (P_Data !== 8'hA5) begin n_fail++; $display("FAIL t3_pdata_hold: got %h want a5", P_Data); end
    dv0 = dv_cnt; se0 = se_cnt;
    send_frame(8'h42, 1'b0, 1'b0, 1'b1);
    idle(12);
    n_checks++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("FAIL t3_recover_dv: got %0d want 1", dv_cnt - dv0); end
    n_checks++; if (P_Data !== 8'h42) begin n_fail++; $display("FAIL t3_recover_pdata: got %h want 42", P_Data); end
    n_checks++; if (se_cnt - se0 !== 0) begin n_fail++; $display("FAIL t3_recover_se: got %0d want 0", se_cnt - se0); end
  endtask

  task automatic test_glitch;
    int dv0, pe0, se0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    RX_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL t4_busy_during: got %b want 1", BUSY); end
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL t4_busy_after: got %b want 0", BUSY); end
    idle(16);
    n_checks++; if (dv_cnt - dv0 !== 0) begin n_fail++; $display("FAIL t4_dv: got %0d want 0", dv_cnt - dv0); end
    n_checks++; if (pe_cnt - pe0 !== 0) begin n_fail++; $display("FAIL t4_pe: got %0d want 0", pe_cnt - pe0); end
    n_checks++; if (se_cnt - se0 !== 0) begin n_fail++; $display("FAIL t4_se: got %0d want 0", se_cnt - se0); end
  endtask

  task automatic test_back_to_back;
    int dv0;
    dv0 = dv_cnt;
    rx_q.delete();
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    idle(12);
    n_checks++; if (dv_cnt - dv0 !== 3) begin n_fail++; $display("FAIL t5_dv_count: got %0d want 3", dv_cnt - dv0); end
    if (rx_q.size() == 3) begin
      n_checks++; if (rx_q[0] !== 8'h00) begin n_fail++; $display("FAIL t5_word0: got %h want 00", rx_q[0]); end
      n_checks++; if (rx_q[1] !== 8'hFF) begin n_fail++; $display("FAIL t5_word1: got %h want ff", rx_q[1]); end
      n_checks++; if (rx_q[2] !== 8'h55) begin n_fail++; $display("FAIL t5_word2: got %h want 55", rx_q[2]); end
    end else begin
      n_checks++; n_fail++;
      $display("FAIL t5_words: got %0d words want 3", rx_q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    int dv0, pe0, se0;
    logic [7:0] d;
    d = 8'h99;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    PAR_EN = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    RX_IN = d[4];
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    n_checks++; if (P_Data !== 8'h00) begin n_fail++; $display("FAIL t6_pdata_reset: got %h want 00", P_Data); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL t6_busy_reset: got %b want 0", BUSY); end
    n_checks++; if (Data_Valid !== 1'b0) begin n_fail++; $display("FAIL t6_dv_reset: got %b want 0", Data_Valid); end
    @(posedge CLK); #1;
    RST = 1'b1;
    idle(20);
    n_checks++; if (dv_cnt - dv0 + pe_cnt - pe0 + se_cnt - se0 !== 0) begin n_fail++; $display("FAIL t6_no_pulses: got %0d want 0", dv_cnt - dv0 + pe_cnt - pe0 + se_cnt - se0); end
    send_frame(8'h99, 1'b0, 1'b0, 1'b1);
    idle(12);
    n_checks++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("FAIL t6_dv_count: got %0d want 1", dv_cnt - dv0); end
    n_checks++; if (P_Data !== 8'h99) begin n_fail++; $display("FAIL t6_pdata: got %h want 99", P_Data); end
    n_checks++; if (se_cnt - se0 !== 0) begin n_fail++; $display("FAIL t6_se: got %0d want 0", se_cnt - se0); end
  endtask

  initial begin
    test_reset();
    test_good_parity();
    test_bad_parity();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
